// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: datapath widths and the tau sequencer state encoding.
package sm4_pkg;

  localparam int unsigned SM4_BYTE_W = 8;
  localparam int unsigned SM4_WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } tau_state_t;

endpackage

// File: rtl/sm4_tau_seq.sv
// sm4_tau_seq: word-level initiator for the byte-serial sm4_sbox handshake.
// Accepts a 32-bit word and pushes its four bytes (MSB first) through an
// external S-box one at a time. Returns tau(A) = (S(a0),S(a1),S(a2),S(a3)).
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   start, din          - request pulse (sampled in idle only) and input word
//   busy                - high from the cycle after acceptance through done
//   done, dout          - one-cycle completion pulse; dout held until next start
//   err                 - timeout flag, pulses with done (0 unless timeout built)
//   sbox_start, sbox_x  - one-cycle S-box request and the byte presented
//   sbox_finish         - S-box result strobe
//   sbox_dout           - S-box result, sampled on sbox_finish
//
// Build option: define SM4_TAU_TIMEOUT_EN to add a per-byte wait limit of
// TIMEOUT_CYCLES; on expiry the block finishes with err=1 and dout=0.
module sm4_tau_seq
  import sm4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SM4_WORD_W-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [SM4_WORD_W-1:0] dout,
  output logic                  err,
  output logic                  sbox_start,
  output logic [SM4_BYTE_W-1:0] sbox_x,
  input  logic                  sbox_finish,
  input  logic [SM4_BYTE_W-1:0] sbox_dout
);

  tau_state_t            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [SM4_WORD_W-1:0] word_q, word_d;
  logic [SM4_WORD_W-1:0] res_q, res_d;
  logic [SM4_WORD_W-1:0] dout_q, dout_d;
  logic                  tmo_hit;

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  tau_timeout_range: assert property (@(posedge clk)
    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255));

`ifdef SM4_TAU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StIssue) begin
      tmo_cnt_d = '0;
    end else if ((state_q == StWait) && !sbox_finish) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  // A finish in the expiring cycle takes priority: the byte is captured instead.
  assign tmo_hit = (state_q == StWait) && !sbox_finish && (tmo_cnt_d == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= tmo_hit;  // set on the edge into done, cleared on the edge out
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    res_d   = res_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = din;
          idx_d   = 2'd3;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (sbox_finish) begin
          res_d[SM4_BYTE_W*idx_q +: SM4_BYTE_W] = sbox_dout;
          if (idx_q == 2'd0) begin
            // Publish the word on entry to done so dout is valid with the pulse.
            dout_d  = res_d;
            state_d = StDone;
          end else begin
            idx_d   = idx_q - 2'd1;
            state_d = StIssue;
          end
        end else if (tmo_hit) begin
          dout_d  = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd3;
      word_q  <= '0;
      res_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign sbox_start = (state_q == StIssue);
  assign dout       = dout_q;
  // Byte held for the whole issue/wait window; zero while not in a transaction.
  assign sbox_x     = ((state_q == StIssue) || (state_q == StWait)) ?
                      word_q[SM4_BYTE_W*idx_q +: SM4_BYTE_W] : '0;

endmodule

// File: tb/tb_sm4_tau_seq.sv
// Bench for sm4_tau_seq with a behavioural S-box of programmable latency.
module tb_sm4_tau_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic        err;
  logic        sbox_start;
  logic [7:0]  sbox_x;
  logic        sbox_finish;
  logic [7:0]  sbox_dout;

  sm4_tau_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .err        (err),
    .sbox_start (sbox_start),
    .sbox_x     (sbox_x),
    .sbox_finish(sbox_finish),
    .sbox_dout  (sbox_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural S-box: only the entries used by the vectors are modelled.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    case (x)
      8'h00:   return 8'hD6;
      8'h01:   return 8'h90;
      8'h02:   return 8'hE9;
      8'h03:   return 8'hFE;
      8'hFF:   return 8'h48;
      default: return 8'h00;
    endcase
  endfunction

  int         sb_lat = 1;
  int         sb_cnt = 0;
  logic [7:0] sb_x   = 8'h00;
  logic       hang   = 1'b0;
  logic       spur   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sb_cnt <= 0;
    end else if (sbox_start) begin
      sb_cnt <= sb_lat;
      sb_x   <= sbox_x;
    end else if (sb_cnt != 0) begin
      sb_cnt <= sb_cnt - 1;
    end
  end

  assign sbox_finish = ((sb_cnt == 1) && !hang) || spur;
  assign sbox_dout   = spur ? 8'hAA : sbox_ref(sb_x);

  // Scoreboard.
  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_x_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: completions and S-box requests.
  initial begin
    exp_t e;
    logic prev_ss;
    logic [7:0] ex;
    prev_ss = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("dout", dout, e.dout);
          chk("err", {31'd0, err}, {31'd0, e.err});
        end
      end
      if (sbox_start) begin
        chk("sbox_start_single", {31'd0, prev_ss}, 32'd0);
        if (exp_x_q.size() == 0) begin
          chk("unexpected_sbox_start", 32'd1, 32'd0);
        end else begin
          ex = exp_x_q.pop_front();
          chk("sbox_x", {24'd0, sbox_x}, {24'd0, ex});
        end
      end
      prev_ss = sbox_start;
    end
  end

  task automatic push_x(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_x_q.push_back(w[31-8*i -: 8]);
  endtask

  // Drive one start pulse in the current cycle; returns at the next negedge.
  task automatic issue(input logic [31:0] w, input bit push, input logic [31:0] exp_dout,
                       input logic exp_err, input int lat);
    exp_t e;
    start = 1'b1;
    din   = w;
    if (push) begin
      e.dout = exp_dout;
      e.err  = exp_err;
      e.cyc  = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_dout"}, dout, 32'd0);
    chk({tag, "_sbox_start"}, {31'd0, sbox_start}, 32'd0);
    chk({tag, "_sbox_x"}, {24'd0, sbox_x}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din   = 32'h0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic run, k=1: done nine cycles after acceptance.
    sb_lat = 1;
    push_x(32'h00010203, 4);
    issue(32'h00010203, 1'b1, 32'hD690E9FE, 1'b0, 9);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("pending_t1", exp_q.size(), 0);
    chk("dout_hold", dout, 32'hD690E9FE);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // k=3: done at cycle 4k+5 = 17.
    sb_lat = 3;
    push_x(32'hFFFFFFFF, 4);
    issue(32'hFFFFFFFF, 1'b1, 32'h48484848, 1'b0, 17);
    repeat (25) @(negedge clk);
    chk("pending_t2", exp_q.size(), 0);

    // Re-pulsed start in cycles 2..8 ignored; back-to-back start in cycle 10 accepted.
    sb_lat = 1;
    push_x(32'h00010203, 4);
    push_x(32'hFFFFFFFF, 4);
    begin
      exp_t e;
      e.dout = 32'hD690E9FE; e.err = 1'b0; e.cyc = cyc + 9;
      exp_q.push_back(e);
      e.dout = 32'h48484848; e.err = 1'b0; e.cyc = cyc + 19;
      exp_q.push_back(e);
    end
    for (int j = 0; j <= 10; j++) begin
      start = (j == 0) || ((j >= 2) && (j <= 8)) || (j == 10);
      din   = (j == 0) ? 32'h00010203 : 32'hFFFFFFFF;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pending_t3", exp_q.size(), 0);

    // Reset during the wait of the third byte: partial result discarded.
    push_x(32'h00010203, 3);
    issue(32'h00010203, 1'b0, 32'h0, 1'b0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    push_x(32'h00010203, 4);
    issue(32'h00010203, 1'b1, 32'hD690E9FE, 1'b0, 9);
    repeat (20) @(negedge clk);
    chk("pending_t4", exp_q.size(), 0);

    // Spurious finish in idle and in the issue cycle is ignored.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    push_x(32'h00010203, 4);
    issue(32'h00010203, 1'b1, 32'hD690E9FE, 1'b0, 9);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (20) @(negedge clk);
    chk("pending_t5", exp_q.size(), 0);

    // S-box never finishes.
    hang = 1'b1;
    push_x(32'h00010203, 1);
`ifdef SM4_TAU_TIMEOUT_EN
    issue(32'h00010203, 1'b1, 32'h0, 1'b1, 18);
    repeat (25) @(negedge clk);
    chk("timeout_idle_busy", {31'd0, busy}, 32'd0);
`else
    issue(32'h00010203, 1'b0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 100; i++) begin
      chk("hang_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    hang = 1'b0;
    @(negedge clk);
    chk("pending_end", exp_q.size(), 0);
    chk("pending_x_end", exp_x_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
